// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: run-state encoding, PCRegSelect codes,
// and the branch-resolution rule shared by the jump logic.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_RUN  = 2'd1,
        F_DONE = 2'd2
    } fetch_state_t;

    localparam logic [1:0] kPC_NONE = 2'b00;
    localparam logic [1:0] kPC_R1   = 2'b01;
    localparam logic [1:0] kPC_R2   = 2'b10;
    localparam logic [1:0] kPC_R3   = 2'b11;

    // je and jne together is illegal and resolves as not taken.
    function automatic logic branch_taken(input logic je, input logic jne, input logic eq);
        return (je ^ jne) && ((je && eq) || (jne && !eq));
    endfunction

endpackage

// File: rtl/fetch_unit_pc_save_regs.sv
// Three saved-address registers (PCreg1-3) addressed by PCRegSelect codes;
// one write port, one combinational read port, async clear plus a synchronous clear.
module pc_save_regs
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            we,
    input  logic [1:0]      wsel,
    input  logic [PC_W-1:0] wdata,
    input  logic [1:0]      rsel,
    output logic [PC_W-1:0] rdata
);

    logic [PC_W-1:0] regs_reg [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) regs_reg[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 3; i++) regs_reg[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < 3; i++) begin
                if (wsel == 2'(i + 1)) regs_reg[i] <= wdata;
            end
        end
    end

    // Read is unregistered so a jump sees the register in the same cycle.
    always_comb begin
        rdata = '0;
        case (rsel)
            kPC_R1:  rdata = regs_reg[0];
            kPC_R2:  rdata = regs_reg[1];
            kPC_R3:  rdata = regs_reg[2];
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and branch-target unit with Start/Ack run sequencing.
// Optional run-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic             Equal,
    output logic [PC_W-1:0]  ProgCounter,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] saved_pc, save_data;
    logic            save_we, clr;
    logic            sel_any, taken, any_jump_flag;

    assign sel_any       = (PCRegSelect != kPC_NONE);
    assign any_jump_flag = JumpEqual | JumpNotEqual;
    assign taken         = sel_any && branch_taken(JumpEqual, JumpNotEqual, Equal);
    assign save_data     = pc_reg + (OffsetEn ? PC_W'(2) : PC_W'(1));

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        save_we    = 1'b0;
        clr        = 1'b0;
        case (state_reg)
            F_IDLE: begin
                clr     = 1'b1;
                pc_next = '0;
                if (!Start) state_next = F_RUN;
            end
            F_RUN: begin
                if (Start) begin
                    state_next = F_IDLE;
                    clr        = 1'b1;
                    pc_next    = '0;
                end else if (Ack) begin
                    state_next = F_DONE;
                end else if (taken) begin
                    pc_next = saved_pc;
                end else begin
                    // An untaken branch still carries a jump flag, which blocks the save.
                    pc_next = pc_reg + PC_W'(1);
                    save_we = sel_any && !any_jump_flag;
                end
            end
            F_DONE: begin
                if (Start) begin
                    state_next = F_IDLE;
                    clr        = 1'b1;
                    pc_next    = '0;
                end
            end
            default: begin
                state_next = F_IDLE;
                clr        = 1'b1;
                pc_next    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= F_IDLE;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    pc_save_regs #(
        .PC_W (PC_W)
    ) u_save_regs (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (clr),
        .we    (save_we),
        .wsel  (PCRegSelect),
        .wdata (save_data),
        .rsel  (PCRegSelect),
        .rdata (saved_pc)
    );

`ifdef FETCH_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (state_reg == F_RUN && cnt_reg != '1) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign CycleCount = cnt_reg;
`else
    assign CycleCount = '0;
`endif

    assign ProgCounter = pc_reg;
    assign Done        = (state_reg == F_DONE);

endmodule
